// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
//
// Scan sequencer wrapped around a 4:1 mux. It walks the mux select lines over
// the enabled channels in ascending order, waits SETTLE_CYCLES cycles on each
// channel, and then samples the mux output. When the last enabled channel has
// been sampled, the collected bits are presented as a 4-bit frame over a
// valid/ready handshake.
//
// Parameters
//   SETTLE_CYCLES : number of cycles each select is held before y_in is
//                   sampled (legal range 1..15)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        scan request, only looked at while idle
//   cont         continuous mode: rescan automatically after each accepted frame
//   chan_en[3:0] channel enable mask, bit k enables mux input ik
//   y_in         mux output y
//   s0, s1       mux selects, {s0,s1} = channel index
//   frame[3:0]   captured samples, bit k = sample of channel k
//   frame_valid  frame holds a complete scan
//   frame_ready  consumer accepts the frame
//   busy         scan in progress or frame waiting to be accepted
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic [3:0] chan_en,
  input  logic       y_in,
  output logic       s0,
  output logic       s1,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
);

  // Counter value on which the current channel is sampled.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx;
  logic [1:0] idx_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [3:0] mask;
  logic [3:0] mask_nxt;
  logic [3:0] sbuf;
  logic [3:0] sbuf_nxt;
  logic [3:0] frame_nxt;
  logic       valid_nxt;
  logic [3:0] captured;

  // Lowest set bit of a non-zero mask; returns 0 for an empty mask.
  function automatic logic [1:0] lowest_chan(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) r = 2'(k);
    end
    return r;
  endfunction

  // True when the mask contains an enabled channel above cur.
  function automatic logic higher_exists(input logic [3:0] m, input logic [1:0] cur);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (m[k] && (k > int'(cur))) r = 1'b1;
    end
    return r;
  endfunction

  // Next enabled channel above cur (cur itself if there is none).
  function automatic logic [1:0] next_chan(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    r = cur;
    for (int k = 3; k >= 0; k--) begin
      if (m[k] && (k > int'(cur))) r = 2'(k);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    mask_nxt  = mask;
    sbuf_nxt  = sbuf;
    frame_nxt = frame;
    valid_nxt = frame_valid;

    // Sample buffer with the current channel's bit replaced by y_in; only
    // committed on the sampling edge.
    captured      = sbuf;
    captured[idx] = y_in;

    unique case (state)
      IDLE: begin
        // An empty mask would never produce a frame, so such a start is dropped.
        if (start && (chan_en != 4'b0000)) begin
          mask_nxt  = chan_en;
          idx_nxt   = lowest_chan(chan_en);
          cnt_nxt   = 4'd0;
          sbuf_nxt  = 4'b0000;
          state_nxt = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt == CNT_LAST) begin
          sbuf_nxt = captured;
          if (higher_exists(mask, idx)) begin
            idx_nxt = next_chan(mask, idx);
            cnt_nxt = 4'd0;
          end else begin
            // Last channel: the frame includes the bit sampled on this edge.
            frame_nxt = captured;
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end

      HOLD: begin
        if (frame_valid && frame_ready) begin
          valid_nxt = 1'b0;
          if (cont && (chan_en != 4'b0000)) begin
            // Continuous mode takes a fresh snapshot of the live mask.
            mask_nxt  = chan_en;
            idx_nxt   = lowest_chan(chan_en);
            cnt_nxt   = 4'd0;
            sbuf_nxt  = 4'b0000;
            state_nxt = SETTLE;
          end else begin
            // Selects park at channel 0 whenever the sequencer is idle.
            idx_nxt   = 2'd0;
            cnt_nxt   = 4'd0;
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        idx_nxt   = 2'd0;
        cnt_nxt   = 4'd0;
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers; reset discards any partial scan
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= 2'd0;
      cnt         <= 4'd0;
      mask        <= 4'b0000;
      sbuf        <= 4'b0000;
      frame       <= 4'b0000;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      mask        <= mask_nxt;
      sbuf        <= sbuf_nxt;
      frame       <= frame_nxt;
      frame_valid <= valid_nxt;
    end
  end

  assign s0   = idx[1];
  assign s1   = idx[0];
  assign busy = (state != IDLE);

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits directly upstream and downstream of the team's 4:1 mux.
- Drives the mux select lines s0/s1 round-robin over the enabled channels.
- Waits a programmable settle time, then samples the mux output y.
- Packs the samples into a 4-bit frame and delivers it over a valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 2, cycles each select is held before y is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a scan; sampled only in IDLE.
- cont  input  1  continuous mode: automatically rescan after each accepted frame.
- chan_en  input  4  channel enable mask; bit k enables mux input ik.
- y_in  input  1  mux output y.
- s0  output  1  mux select, MSB of channel index.
- s1  output  1  mux select, LSB of channel index.
- frame  output  4  captured samples; bit k = sample of channel k.
- frame_valid  output  1  frame holds a complete scan.
- frame_ready  input  1  consumer accepts the frame.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All state is registered on the clk rising edge.
- Reset values: s0=0, s1=0, frame=0, frame_valid=0, busy=0, state=IDLE, internal channel index=0, settle counter=0, mask snapshot=0.
- Channel index k maps to selects as {s0,s1}=k: 00→i0, 01→i1, 10→i2, 11→i3. s0/s1 are registered outputs driven directly from the index register.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - busy=0, selects held at 00.
  - start=1 and chan_en≠0: snapshot chan_en, load index with the lowest enabled channel, clear counter, go to SETTLE.
  - start=1 and chan_en=0: ignored, stay in IDLE.
- SETTLE:
  - Counter increments each cycle.
  - On the edge where counter==SETTLE_CYCLES-1, y_in is captured into buffer bit [index].
  - If a higher-numbered enabled channel exists in the snapshot: index moves to it, counter clears, stay in SETTLE.
  - Otherwise, on that same edge: frame loads the buffer including the new bit, frame_valid←1, go to HOLD.
  - Bits of disabled channels are 0 in the frame.
- Latency: with E enabled channels, frame_valid rises on edge E×SETTLE_CYCLES after the edge that sampled start.
- HOLD:
  - frame and frame_valid are held stable until frame_ready=1; backpressure is unbounded.
  - Handshake occurs on an edge where frame_valid=1 and frame_ready=1.
  - On handshake with cont=0: frame_valid←0, go to IDLE.
  - On handshake with cont=1 and live chan_en≠0: re-snapshot chan_en, restart at its lowest enabled channel; frame_valid←0 on that same edge.
  - On handshake with cont=1 and chan_en=0: go to IDLE.
- frame holds its last value after the handshake until the next scan completes.
- chan_en changes during a scan have no effect until the next snapshot.
- start while busy is ignored. frame_ready outside HOLD is ignored.
- rst_n low at any time, including mid-scan, immediately forces all reset values. A partial buffer is discarded and no frame is emitted.

Test Plan:
- SETTLE_CYCLES=2, chan_en=1111, mux inputs i0..i3=1,0,1,1, frame_ready=1, pulse start → s0s1 sequence 00,01,10,11, each held 2 cycles; frame=4'b1101 with frame_valid on edge 8; then IDLE, busy=0.
- chan_en=0101, i0=1, i2=1 → only selects 00 and 10 appear; frame=4'b0101 on edge 4; bits 1 and 3 read 0 even with i1=i3=1.
- Backpressure: frame_ready=0 for 20 cycles after frame_valid → frame and frame_valid stable throughout; frame_valid drops on the edge after frame_ready rises.
- cont=1, chan_en=1000, i3 toggling → consecutive frames 1000/0000 alternate; selects stay at 11; busy stays high until cont=0 at a handshake.
- start with chan_en=0000 → no state change, busy=0. start while busy → scan unaffected.
- rst_n pulsed low asynchronously mid-scan at channel 2 → s0=s1=0, frame=0, frame_valid=0, busy=0 immediately; a fresh start after release completes a normal scan.
